// File: rtl/memory_arbiter.sv
// Purpose: shares one memory port between the core (r0) and a loader/DMA master (r1), one transaction in flight.
// Latency: one arbitration cycle (IDLE) before memory_enable; accept and completion are forwarded combinationally.
// Backpressure: only the owner sees memory_ready/memory_valid; a losing requester holds its request until granted.
module memory_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_memory_enable,
    input  logic        r0_memory_command,
    input  logic [31:0] r0_read_memory_address,
    input  logic [31:0] r0_write_memory_address,
    input  logic [31:0] r0_write_memory_data,
    input  logic [31:0] r0_write_memory_mask,
    output logic        r0_memory_ready,
    output logic        r0_memory_valid,
    output logic [31:0] r0_read_memory_data,

    input  logic        r1_memory_enable,
    input  logic        r1_memory_command,
    input  logic [31:0] r1_read_memory_address,
    input  logic [31:0] r1_write_memory_address,
    input  logic [31:0] r1_write_memory_data,
    input  logic [31:0] r1_write_memory_mask,
    output logic        r1_memory_ready,
    output logic        r1_memory_valid,
    output logic [31:0] r1_read_memory_data,

    output logic        memory_enable,
    output logic        memory_command,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] read_memory_data,

    output logic [1:0]  debug_grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last;
    logic   winner;

    logic        own_enable;
    logic        own_command;
    logic [31:0] own_read_address;
    logic [31:0] own_write_address;
    logic [31:0] own_write_data;
    logic [31:0] own_write_mask;

    // Pick the requester to grant from IDLE; under contention either r0 always or the one not served last.
    always_comb begin
        winner = 1'b0;
        if (r0_memory_enable && r1_memory_enable) begin
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
        end else if (r1_memory_enable) begin
            winner = 1'b1;
        end
    end

    // Select the current owner's request fields.
    always_comb begin
        own_enable        = r0_memory_enable;
        own_command       = r0_memory_command;
        own_read_address  = r0_read_memory_address;
        own_write_address = r0_write_memory_address;
        own_write_data    = r0_write_memory_data;
        own_write_mask    = r0_write_memory_mask;
        if (owner) begin
            own_enable        = r1_memory_enable;
            own_command       = r1_memory_command;
            own_read_address  = r1_read_memory_address;
            own_write_address = r1_write_memory_address;
            own_write_data    = r1_write_memory_data;
            own_write_mask    = r1_write_memory_mask;
        end
    end

    // Arbitration state machine; debug_grant tracks the owner and is cleared whenever we return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            debug_grant <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (r0_memory_enable || r1_memory_enable) begin
                        owner       <= winner;
                        debug_grant <= winner ? 2'b10 : 2'b01;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (own_enable && memory_ready) begin
                        last  <= owner;
                        state <= ST_WAIT;
                    end else if (!own_enable) begin
                        // Owner withdrew before the memory took the request: nothing is in flight.
                        debug_grant <= 2'b00;
                        state       <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (memory_valid) begin
                        debug_grant <= 2'b00;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    debug_grant <= 2'b00;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the memory port and the per-requester handshakes; memory_valid outside WAIT is spurious and dropped.
    always_comb begin
        memory_enable        = 1'b0;
        memory_command       = 1'b0;
        read_memory_address  = 32'h0;
        write_memory_address = 32'h0;
        write_memory_data    = 32'h0;
        write_memory_mask    = 32'h0;
        r0_memory_ready      = 1'b0;
        r1_memory_ready      = 1'b0;
        r0_memory_valid      = 1'b0;
        r1_memory_valid      = 1'b0;
        if (state == ST_GRANT || state == ST_WAIT) begin
            memory_command       = own_command;
            read_memory_address  = own_read_address;
            write_memory_address = own_write_address;
            write_memory_data    = own_write_data;
            write_memory_mask    = own_write_mask;
        end
        if (state == ST_GRANT) begin
            memory_enable   = own_enable;
            r0_memory_ready = ~owner & memory_ready;
            r1_memory_ready =  owner & memory_ready;
        end
        if (state == ST_WAIT) begin
            r0_memory_valid = ~owner & memory_valid;
            r1_memory_valid =  owner & memory_valid;
        end
    end

    // Read data goes to both requesters; only the owner's valid qualifies it.
    assign r0_read_memory_data = read_memory_data;
    assign r1_read_memory_data = read_memory_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Purpose: directed and randomized checking of memory_arbiter (round-robin and fixed-priority instances).
// Latency: inputs change on the falling edge, outputs are sampled 2 time units later.
// Backpressure: random memory_ready stalls and random completion latency in the random phase.
module tb_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        r0_memory_enable, r0_memory_command;
    logic [31:0] r0_read_memory_address, r0_write_memory_address, r0_write_memory_data, r0_write_memory_mask;
    logic        r1_memory_enable, r1_memory_command;
    logic [31:0] r1_read_memory_address, r1_write_memory_address, r1_write_memory_data, r1_write_memory_mask;
    logic        memory_ready, memory_valid;
    logic [31:0] read_memory_data;

    logic        r0_memory_ready, r0_memory_valid, r1_memory_ready, r1_memory_valid;
    logic [31:0] r0_read_memory_data, r1_read_memory_data;
    logic        memory_enable, memory_command;
    logic [31:0] read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
    logic [1:0]  debug_grant;

    logic        fp_r0_memory_ready, fp_r0_memory_valid, fp_r1_memory_ready, fp_r1_memory_valid;
    logic [31:0] fp_r0_read_memory_data, fp_r1_read_memory_data;
    logic        fp_memory_enable, fp_memory_command;
    logic [31:0] fp_read_memory_address, fp_write_memory_address, fp_write_memory_data, fp_write_memory_mask;
    logic [1:0]  fp_debug_grant;

    memory_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .r0_memory_enable(r0_memory_enable), .r0_memory_command(r0_memory_command),
        .r0_read_memory_address(r0_read_memory_address), .r0_write_memory_address(r0_write_memory_address),
        .r0_write_memory_data(r0_write_memory_data), .r0_write_memory_mask(r0_write_memory_mask),
        .r0_memory_ready(r0_memory_ready), .r0_memory_valid(r0_memory_valid), .r0_read_memory_data(r0_read_memory_data),
        .r1_memory_enable(r1_memory_enable), .r1_memory_command(r1_memory_command),
        .r1_read_memory_address(r1_read_memory_address), .r1_write_memory_address(r1_write_memory_address),
        .r1_write_memory_data(r1_write_memory_data), .r1_write_memory_mask(r1_write_memory_mask),
        .r1_memory_ready(r1_memory_ready), .r1_memory_valid(r1_memory_valid), .r1_read_memory_data(r1_read_memory_data),
        .memory_enable(memory_enable), .memory_command(memory_command),
        .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
        .write_memory_data(write_memory_data), .write_memory_mask(write_memory_mask),
        .memory_ready(memory_ready), .memory_valid(memory_valid), .read_memory_data(read_memory_data),
        .debug_grant(debug_grant)
    );

    memory_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .r0_memory_enable(r0_memory_enable), .r0_memory_command(r0_memory_command),
        .r0_read_memory_address(r0_read_memory_address), .r0_write_memory_address(r0_write_memory_address),
        .r0_write_memory_data(r0_write_memory_data), .r0_write_memory_mask(r0_write_memory_mask),
        .r0_memory_ready(fp_r0_memory_ready), .r0_memory_valid(fp_r0_memory_valid), .r0_read_memory_data(fp_r0_read_memory_data),
        .r1_memory_enable(r1_memory_enable), .r1_memory_command(r1_memory_command),
        .r1_read_memory_address(r1_read_memory_address), .r1_write_memory_address(r1_write_memory_address),
        .r1_write_memory_data(r1_write_memory_data), .r1_write_memory_mask(r1_write_memory_mask),
        .r1_memory_ready(fp_r1_memory_ready), .r1_memory_valid(fp_r1_memory_valid), .r1_read_memory_data(fp_r1_read_memory_data),
        .memory_enable(fp_memory_enable), .memory_command(fp_memory_command),
        .read_memory_address(fp_read_memory_address), .write_memory_address(fp_write_memory_address),
        .write_memory_data(fp_write_memory_data), .write_memory_mask(fp_write_memory_mask),
        .memory_ready(memory_ready), .memory_valid(memory_valid), .read_memory_data(read_memory_data),
        .debug_grant(fp_debug_grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        r0_memory_enable = 0; r0_memory_command = 0; r0_read_memory_address = 0;
        r0_write_memory_address = 0; r0_write_memory_data = 0; r0_write_memory_mask = 0;
        r1_memory_enable = 0; r1_memory_command = 0; r1_read_memory_address = 0;
        r1_write_memory_address = 0; r1_write_memory_data = 0; r1_write_memory_mask = 0;
        memory_ready = 0; memory_valid = 0; read_memory_data = 0;
    endtask

    // Every non-data output of both instances must be at its idle/reset value.
    task automatic check_all_zero(input string tag);
        chk({tag, "_men"},   memory_enable, 0);
        chk({tag, "_cmd"},   memory_command, 0);
        chk({tag, "_ra"},    read_memory_address, 0);
        chk({tag, "_wa"},    write_memory_address, 0);
        chk({tag, "_wd"},    write_memory_data, 0);
        chk({tag, "_wm"},    write_memory_mask, 0);
        chk({tag, "_rdy"},   {r0_memory_ready, r1_memory_ready}, 0);
        chk({tag, "_vld"},   {r0_memory_valid, r1_memory_valid}, 0);
        chk({tag, "_dbg"},   debug_grant, 0);
        chk({tag, "_fp_mem"}, {fp_memory_enable, fp_memory_command} | fp_read_memory_address | fp_write_memory_address
                               | fp_write_memory_data | fp_write_memory_mask, 0);
        chk({tag, "_fp_hs"},  {fp_r0_memory_ready, fp_r1_memory_ready, fp_r0_memory_valid, fp_r1_memory_valid, fp_debug_grant}, 0);
    endtask

    // Random-phase reference model state: per-requester pending request, memory-side outstanding transaction.
    logic        pend [2];
    int          start [2];
    logic        mcmd [2];
    logic [31:0] mra [2], mwa [2], mwd [2], mwm [2];

    initial begin
        int rr_g[$], fp_g[$], fp_after[$];
        logic [1:0] rr_dg[$];
        bit outst;
        int acc_owner, prev_acc, grant_start, cyc, completed, x, y;
        bit prev_men, newly;
        logic [1:0] exp_dg;

        clear_inputs();
        reset = 1;

        // ---- reset state (request present during reset must not leak out)
        @(negedge clk);
        r0_memory_enable = 1; r0_read_memory_address = 32'h100;
        @(negedge clk); #2;
        check_all_zero("reset");

        // ---- single read by r0
        @(negedge clk); reset = 0; memory_ready = 1; #2;
        chk("t1_idle_men", memory_enable, 0);
        @(negedge clk); #2;
        chk("t1_grant_men", memory_enable, 1);
        chk("t1_grant_ra", read_memory_address, 32'h100);
        chk("t1_grant_cmd", memory_command, 0);
        chk("t1_r0_rdy", r0_memory_ready, 1);
        chk("t1_r1_rdy", r1_memory_ready, 0);
        chk("t1_dbg", debug_grant, 2'b01);
        @(negedge clk); r0_memory_enable = 0; memory_ready = 0; #2;
        chk("t1_wait_men", memory_enable, 0);
        chk("t1_wait_ra", read_memory_address, 32'h100);
        chk("t1_wait_rdy", r0_memory_ready, 0);
        chk("t1_wait_vld", r0_memory_valid, 0);
        chk("t1_wait_dbg", debug_grant, 2'b01);
        @(negedge clk); memory_valid = 1; read_memory_data = 32'hDEADBEEF; #2;
        chk("t1_r0_vld", r0_memory_valid, 1);
        chk("t1_r0_data", r0_read_memory_data, 32'hDEADBEEF);
        chk("t1_r1_vld", r1_memory_valid, 0);
        chk("t1_r1_data", r1_read_memory_data, 32'hDEADBEEF);
        @(negedge clk); memory_valid = 0; r0_read_memory_address = 0; #2;
        check_all_zero("t1_idle");

        // ---- r1 masked write with three stall cycles
        @(negedge clk);
        r1_memory_enable = 1; r1_memory_command = 1; r1_write_memory_address = 32'h2000;
        r1_write_memory_data = 32'h12345678; r1_write_memory_mask = 32'h0000FFFF; #2;
        chk("t3_idle_men", memory_enable, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("t3_stall_men", memory_enable, 1);
            chk("t3_stall_wa", write_memory_address, 32'h2000);
            chk("t3_stall_wd", write_memory_data, 32'h12345678);
            chk("t3_stall_wm", write_memory_mask, 32'h0000FFFF);
            chk("t3_stall_cmd", memory_command, 1);
            chk("t3_stall_rdy", {r0_memory_ready, r1_memory_ready}, 0);
        end
        @(negedge clk); memory_ready = 1; #2;
        chk("t3_acc_rdy", {r0_memory_ready, r1_memory_ready}, 2'b01);
        chk("t3_acc_dbg", debug_grant, 2'b10);
        @(negedge clk); r1_memory_enable = 0; memory_ready = 0; memory_valid = 1; #2;
        chk("t3_vld", {r0_memory_valid, r1_memory_valid}, 2'b01);
        chk("t3_wait_men", memory_enable, 0);
        chk("t3_wait_wa", write_memory_address, 32'h2000);
        @(negedge clk); memory_valid = 0; clear_inputs(); #2;
        check_all_zero("t3_idle");

        // ---- spurious valid in IDLE, then a request withdrawn in GRANT
        @(negedge clk); memory_valid = 1; #2;
        chk("t5_spur_vld", {r0_memory_valid, r1_memory_valid}, 0);
        chk("t5_spur_men", memory_enable, 0);
        @(negedge clk); memory_valid = 0; r0_memory_enable = 1; r0_read_memory_address = 32'h44; #2;
        chk("t5_idle_men", memory_enable, 0);
        @(negedge clk); #2;
        chk("t5_grant_men", memory_enable, 1);
        chk("t5_grant_dbg", debug_grant, 2'b01);
        @(negedge clk); r0_memory_enable = 0; memory_valid = 1; #2;
        chk("t5_drop_men", memory_enable, 0);
        chk("t5_drop_rdy", r0_memory_ready, 0);
        chk("t5_drop_vld", {r0_memory_valid, r1_memory_valid}, 0);
        @(negedge clk); memory_valid = 0; #2;
        chk("t5_back_idle_dbg", debug_grant, 0);
        chk("t5_back_idle_men", memory_enable, 0);

        // ---- reset while r0 is in WAIT; afterwards r0 must win the first contention
        @(negedge clk); r0_memory_enable = 1; r0_read_memory_address = 32'h300; memory_ready = 1; #2;
        @(negedge clk); #2;
        chk("t4_acc_rdy", r0_memory_ready, 1);
        @(negedge clk); r0_memory_enable = 0; memory_ready = 0; reset = 1; #2;
        chk("t4_wait_dbg", debug_grant, 2'b01);
        @(negedge clk); memory_valid = 1; #2;
        check_all_zero("t4_in_reset");
        @(negedge clk); reset = 0; #2;
        check_all_zero("t4_after_reset");
        @(negedge clk); memory_valid = 0; r0_memory_enable = 1; r1_memory_enable = 1;
        r1_read_memory_address = 32'h500; #2;
        @(negedge clk); #2;
        chk("t4_first_dbg", debug_grant, 2'b01);
        chk("t4_first_ra", read_memory_address, 32'h300);
        chk("t4_fp_first_dbg", fp_debug_grant, 2'b01);
        @(negedge clk); clear_inputs(); #2;
        @(negedge clk); #2;
        check_all_zero("t4_idle");

        // ---- continuous contention, memory always ready, completes the cycle after accept
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        r0_memory_enable = 1; r1_memory_enable = 1; memory_ready = 1; memory_valid = 1;
        for (int c = 0; c < 22; c++) begin
            if (c == 14) r0_memory_enable = 0;
            #2;
            if (memory_enable && memory_ready) begin
                rr_g.push_back(r1_memory_ready ? 1 : 0);
                rr_dg.push_back(debug_grant);
            end
            if (fp_memory_enable && memory_ready) begin
                if (c < 14) fp_g.push_back(fp_r1_memory_ready ? 1 : 0);
                else        fp_after.push_back(fp_r1_memory_ready ? 1 : 0);
            end
            @(negedge clk);
        end
        chk("t2_rr_count", rr_g.size() >= 4, 1);
        chk("t2_fp_count", fp_g.size() >= 4, 1);
        chk("t2_fp_after_count", fp_after.size() >= 1, 1);
        for (int i = 0; i < 4 && i < rr_g.size(); i++) begin
            chk("t2_rr_order", rr_g[i], i % 2);
            chk("t2_rr_dbg", rr_dg[i], (i % 2) ? 2'b10 : 2'b01);
        end
        foreach (fp_g[i]) chk("t2_fp_r0_wins", fp_g[i], 0);
        foreach (fp_after[i]) chk("t2_fp_r1_after_drop", fp_after[i], 1);
        clear_inputs();

        // ---- randomized traffic against a transaction-level model of the round-robin instance
        reset = 1;
        @(negedge clk); @(negedge clk); reset = 0;
        outst = 0; acc_owner = 0; prev_acc = 1; grant_start = 0; cyc = 0; completed = 0; prev_men = 0;
        for (int n = 0; n < 2; n++) begin pend[n] = 0; start[n] = 0; end
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 1) == 1) begin
                    pend[n] = 1; start[n] = cyc; mcmd[n] = 1'($urandom_range(0, 1));
                    mra[n] = $urandom; mwa[n] = $urandom; mwd[n] = $urandom; mwm[n] = $urandom;
                end
            end
            r0_memory_enable = pend[0]; r0_memory_command = mcmd[0]; r0_read_memory_address = mra[0];
            r0_write_memory_address = mwa[0]; r0_write_memory_data = mwd[0]; r0_write_memory_mask = mwm[0];
            r1_memory_enable = pend[1]; r1_memory_command = mcmd[1]; r1_read_memory_address = mra[1];
            r1_write_memory_address = mwa[1]; r1_write_memory_data = mwd[1]; r1_write_memory_mask = mwm[1];
            memory_ready = ($urandom_range(0, 2) != 0);
            memory_valid = outst ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            read_memory_data = $urandom;
            #2;
            if (memory_enable && !prev_men) grant_start = cyc;
            chk("rnd_bcast0", r0_read_memory_data, read_memory_data);
            chk("rnd_bcast1", r1_read_memory_data, read_memory_data);
            chk("rnd_fp_bcast", fp_r0_read_memory_data ^ fp_r1_read_memory_data, 0);
            chk("rnd_ready_any", r0_memory_ready | r1_memory_ready, memory_enable & memory_ready);
            chk("rnd_ready_excl", r0_memory_ready & r1_memory_ready, 0);
            chk("rnd_dbg_busy", debug_grant != 2'b00, outst || memory_enable);
            if (outst) chk("rnd_dbg_owner", debug_grant, (acc_owner == 1) ? 2'b10 : 2'b01);
            newly = 0;
            if (r0_memory_ready || r1_memory_ready) begin
                x = r1_memory_ready ? 1 : 0;
                y = 1 - x;
                exp_dg = (x == 1) ? 2'b10 : 2'b01;
                chk("rnd_acc_pending", pend[x], 1);
                chk("rnd_acc_cmd", memory_command, mcmd[x]);
                chk("rnd_acc_ra", read_memory_address, mra[x]);
                chk("rnd_acc_wa", write_memory_address, mwa[x]);
                chk("rnd_acc_wd", write_memory_data, mwd[x]);
                chk("rnd_acc_wm", write_memory_mask, mwm[x]);
                chk("rnd_acc_dbg", debug_grant, exp_dg);
                chk("rnd_fair", (prev_acc == x) && pend[y] && (start[y] < grant_start), 0);
                prev_acc = x;
                pend[x] = 0;
                newly = 1;
            end
            chk("rnd_vld0", r0_memory_valid, outst && memory_valid && acc_owner == 0);
            chk("rnd_vld1", r1_memory_valid, outst && memory_valid && acc_owner == 1);
            if (outst && memory_valid) begin
                outst = 0;
                completed++;
            end
            if (newly) begin
                outst = 1;
                acc_owner = x;
            end
            prev_men = memory_enable;
            cyc++;
        end
        chk("rnd_progress", completed > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
